dmem_responder: RTL

Data-memory responder at the far end of the CPU's load/store path: accepts the enable, 4-bit byte-lane write enable, address and lane-replicated write data that the MEM-stage translator produces, and returns a raw 32-bit read word for the translator to extract and extend. It models a wait-stated on-chip data RAM, holding the pipeline with a stall signal until each access completes. It sits between the MEM stage and the data RAM macro, replacing the zero-latency ideal memory.

---
 rtl/dmem_pkg.sv | 18 +
 rtl/dmem_byte_ram.sv | 32 +++
 rtl/dmem_responder.sv | 124 ++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared FSM encoding, lane width and counter sizing for the data-memory responder
package dmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int LANES = 4;

  // Wait counter must hold WAIT_CYCLES; keep at least one bit so WAIT_CYCLES=0 still elaborates.
  function automatic int cnt_width(input int wait_cycles);
    if (wait_cycles < 1) return 1;
    return $clog2(wait_cycles + 1);
  endfunction

endpackage

// File: rtl/dmem_byte_ram.sv
// rtl/dmem_byte_ram.sv - DEPTH_WORDS x 32 RAM with per-byte write enables and a registered read port
module dmem_byte_ram #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [3:0]    we,
  input  logic          re,
  input  logic          rd_kill,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  import dmem_pkg::*;

  logic [31:0] mem [DEPTH_WORDS];

  // Byte-lane write; storage itself is never reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (we[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
    end
  end

  // Read register only loads on a read; it holds its value across writes and idle cycles.
  always_ff @(posedge clk) begin
    if (rst)       rdata <= 32'h0;
    else if (re)   rdata <= rd_kill ? 32'h0 : mem[addr];
  end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - wait-stated data-memory responder; optional range check under DMEM_RANGE_CHK_EN
module dmem_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_en,
  input  logic [3:0]  mem_wen,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_stall,
  output logic        mem_err
);
  import dmem_pkg::*;

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CW = cnt_width(WAIT_CYCLES);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [AW-1:0]    idx_q;
  logic [LANES-1:0] wen_q;
  logic [31:0]      wdata_q;
  logic             do_access;
  logic             accept;
  logic             range_bad;
  logic [LANES-1:0] ram_we;
  logic             ram_re;
  logic [31:0]      offset;

  assign offset = mem_addr - BASE_ADDR;
  assign accept = (state_q == ST_IDLE) && mem_en;

  // Byte-offset bits and index bits beyond the RAM depth do not select storage.
  logic unused_offset_bits;
  assign unused_offset_bits = &{1'b0, offset[1:0], offset[31:AW+2]};

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next state: DONE always falls back to IDLE so a held request is not replayed.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (mem_en) state_d = ST_BUSY;
      ST_BUSY: if (cnt_q == '0) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs: stall is combinational so the pipeline freezes in the request cycle itself.
  always_comb begin
    mem_stall = 1'b0;
    do_access = 1'b0;
    if (!rst) mem_stall = accept || (state_q == ST_BUSY);
    if (state_q == ST_BUSY && cnt_q == '0) do_access = 1'b1;
  end

  // Request latch and wait counter; the latched copy is used for the whole access.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      wen_q   <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      cnt_q   <= CW'(WAIT_CYCLES);
      idx_q   <= offset[AW+1:2];
      wen_q   <= mem_wen;
      wdata_q <= mem_wdata;
    end else if (state_q == ST_BUSY && cnt_q != '0) begin
      cnt_q   <= cnt_q - CW'(1);
    end
  end

`ifdef DMEM_RANGE_CHK_EN
  logic flag_q;
  logic err_q;

  // Out-of-range index is decided once, when the request is latched.
  always_ff @(posedge clk) begin
    if (rst)         flag_q <= 1'b0;
    else if (accept) flag_q <= ({2'b00, offset[31:2]} >= 32'(DEPTH_WORDS));
  end

  // Error pulse lands in the DONE cycle of the flagged access.
  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= do_access && flag_q;
  end

  assign range_bad = flag_q;
  assign mem_err   = err_q;
`else
  assign range_bad = 1'b0;
  assign mem_err   = 1'b0;
`endif

  // A reset on the access edge cancels the write; flagged writes never reach the array.
  assign ram_we = (do_access && !rst && !range_bad) ? wen_q : '0;
  assign ram_re = do_access && !rst && (wen_q == '0);

  dmem_byte_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .we      (ram_we),
    .re      (ram_re),
    .rd_kill (range_bad),
    .addr    (idx_q),
    .wdata   (wdata_q),
    .rdata   (mem_rdata)
  );

endmodule
